// File: rtl/psum_ctrl_pkg.sv
// Shared constants for the partial-sum read-modify-write controller:
// FSM state encodings and round-robin grant encodings.
package psum_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACC_RD  = 3'd1;
    localparam logic [2:0] ST_ACC_WR  = 3'd2;
    localparam logic [2:0] ST_DRN_RD  = 3'd3;
    localparam logic [2:0] ST_DRN_OUT = 3'd4;
    localparam logic [2:0] ST_DRN_CLR = 3'd5;

    localparam logic GNT_ACC = 1'b0;
    localparam logic GNT_DRN = 1'b1;

endpackage

// File: rtl/psum_rr_arb.sv
// Two-way round-robin arbiter between accumulate and drain requests.
// The pointer holds the last grant and resets to drain, so accumulate wins first.
module psum_rr_arb
    import psum_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_acc,
    input  logic req_drn,
    output logic gnt_acc,
    output logic gnt_drn
);

    logic last_q;

    always_comb begin
        gnt_acc = 1'b0;
        gnt_drn = 1'b0;
        if (en) begin
            if (req_acc && req_drn) begin
                gnt_acc = (last_q == GNT_DRN);
                gnt_drn = (last_q == GNT_ACC);
            end else begin
                gnt_acc = req_acc;
                gnt_drn = req_drn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        last_q <= GNT_DRN;
        else if (gnt_acc) last_q <= GNT_ACC;
        else if (gnt_drn) last_q <= GNT_DRN;
    end

endmodule

// File: rtl/psum_rmw_ctrl.sv
// Partial-sum buffer read-modify-write controller with drain/readout path.
// Define PSUM_SAT_EN to saturate overflowing sums instead of wrapping.
module psum_rmw_ctrl
    import psum_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_data,
    input  logic              acc_first,
    input  logic              drain_valid,
    output logic              drain_ready,
    input  logic [ADDR_W-1:0] drain_addr,
    input  logic              drain_clr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              overflow
);

    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              first_q;
    logic              clr_q;
    logic              gnt_acc;
    logic              gnt_drn;
    logic [DATA_W-1:0] sum_wrap;
    logic [DATA_W-1:0] sum;
    logic              add_ovf;

    psum_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      ((state_q == ST_IDLE) && !reset),
        .req_acc (acc_valid),
        .req_drn (drain_valid),
        .gnt_acc (gnt_acc),
        .gnt_drn (gnt_drn)
    );

    assign acc_ready   = gnt_acc;
    assign drain_ready = gnt_drn;
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        sum_wrap = mem_rdata + data_q;
        add_ovf  = (mem_rdata[DATA_W-1] == data_q[DATA_W-1]) &&
                   (sum_wrap[DATA_W-1] != mem_rdata[DATA_W-1]);
`ifdef PSUM_SAT_EN
        sum = add_ovf ? (mem_rdata[DATA_W-1] ? S_MIN : S_MAX) : sum_wrap;
`else
        sum = sum_wrap;
`endif
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_ACC_RD, ST_DRN_RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
            end
            ST_ACC_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = first_q ? data_q : sum;
            end
            ST_DRN_CLR: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            first_q  <= 1'b0;
            clr_q    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= (state_q == ST_DRN_OUT);
            case (state_q)
                ST_IDLE: begin
                    if (gnt_acc) begin
                        addr_q  <= acc_addr;
                        data_q  <= acc_data;
                        first_q <= acc_first;
                        state_q <= acc_first ? ST_ACC_WR : ST_ACC_RD;
                    end else if (gnt_drn) begin
                        addr_q  <= drain_addr;
                        clr_q   <= drain_clr;
                        state_q <= ST_DRN_RD;
                    end
                end
                ST_ACC_RD: state_q <= ST_ACC_WR;
                ST_ACC_WR: begin
                    if (!first_q && add_ovf) overflow <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_DRN_RD: state_q <= ST_DRN_OUT;
                ST_DRN_OUT: begin
                    rd_data <= mem_rdata;
                    state_q <= clr_q ? ST_DRN_CLR : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/psum_rmw_ctrl.md
PSUM_RMW_CTRL -- requirements
Module: psum_rmw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, psum buffer address width.
REQ-002 SHALL have parameter DATA_W, default 16, signed psum width.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port acc_valid  in  1  accumulate request.
REQ-006 SHALL have port acc_ready  out  1  accumulate request accepted this cycle.
REQ-007 SHALL have port acc_addr  in  ADDR_W  accumulate target address.
REQ-008 SHALL have port acc_data  in  DATA_W  signed addend.
REQ-009 SHALL have port acc_first  in  1  overwrite with acc_data instead of adding.
REQ-010 SHALL have port drain_valid  in  1  readout request.
REQ-011 SHALL have port drain_ready  out  1  readout request accepted this cycle.
REQ-012 SHALL have port drain_addr  in  ADDR_W  readout address.
REQ-013 SHALL have port drain_clr  in  1  zero the entry after readout.
REQ-014 SHALL have port rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-015 SHALL have port rd_data  out  DATA_W  drained psum.
REQ-016 SHALL have ports mem_en, mem_we  out  1  buffer enable and write enable.
REQ-017 SHALL have ports mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W (valid one cycle after a read).
REQ-018 SHALL have ports busy  out  1  (state not IDLE); overflow  out  1  sticky overflow flag.

Function
REQ-019 SHALL implement FSM states IDLE, ACC_RD, ACC_WR, DRN_RD, DRN_OUT, DRN_CLR.
REQ-020 SHALL accept requests only in IDLE; transfer occurs on valid&ready; at most one of acc_ready/drain_ready high per cycle.
REQ-021 SHALL arbitrate when both valid by round-robin: grant the requester not granted last; last-grant pointer resets to drain, so accumulate wins the first contention.
REQ-022 SHALL capture addr/data/flags at transfer; inputs are ignored thereafter until IDLE.
REQ-023 SHALL on accepted accumulate with acc_first=0: IDLE->ACC_RD (read at addr)->ACC_WR (write mem_rdata+data)->IDLE; 3 cycles, ready again in IDLE.
REQ-024 SHALL on accepted accumulate with acc_first=1: IDLE->ACC_WR writing data unchanged, no read; 2 cycles.
REQ-025 SHALL on accepted drain: IDLE->DRN_RD->DRN_OUT capture mem_rdata into rd_data and pulse rd_valid the following cycle; DRN_OUT->DRN_CLR (write 0) if drain_clr, else ->IDLE.
REQ-026 SHALL perform the add as signed DATA_W; overflow set when operand signs agree and the result sign differs; cleared only by reset.
REQ-027 SHALL hold rd_data until the next drain completes; mem_en=mem_we=0 in IDLE.

Reset
REQ-028 SHALL on reset, at any time, go to IDLE, abandon any in-flight operation without a write, and drive acc_ready, drain_ready, rd_valid, mem_en, mem_we, busy, overflow to 0 and rd_data, mem_addr, mem_wdata to 0.

Configuration
REQ-029 SHALL, with PSUM_SAT_EN defined, saturate overflowing sums to the signed max/min of DATA_W; without it, wrap modulo 2^DATA_W; overflow flag behaves identically in both.

Structure
REQ-030 SHALL place state encoding and grant encoding constants in shared package psum_ctrl_pkg.
REQ-031 SHALL instantiate sub-module psum_rr_arb (two-way round-robin arbiter with pointer).

Verification
REQ-032 SHALL test: mem[5]=10, acc addr5 data 7 first=0 -> mem_we in cycle 3 with mem_wdata 17; acc_ready low cycles 2-3.
REQ-033 SHALL test: acc addr3 data -4 first=1 -> single write of -4, no mem read issued.
REQ-034 SHALL test: acc and drain valid in same cycle from reset, repeated -> grants alternate acc, drain, acc.
REQ-035 SHALL test: mem[9]=42, drain addr9 clr=1 -> rd_valid one pulse with 42, then mem[9] written 0.
REQ-036 SHALL test: DATA_W=16, mem[0]=32767, add 1 -> 32767 with PSUM_SAT_EN, -32768 without; overflow=1 both.
REQ-037 SHALL test: reset asserted in ACC_RD -> no write, state IDLE, all outputs 0 next cycle.
